// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM states and access-size codes.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for one 64-bit word: store merge, load extract/extend,
// byte enables and natural-alignment check.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [63:0] wdata_i,
  input  logic [63:0] word_i,
  output logic [7:0]  be_o,
  output logic [63:0] merged_o,
  output logic [63:0] rdata_o,
  output logic        misalign_o
);

  logic [7:0]  mask;
  logic [63:0] wsh;
  logic [63:0] rsh;
  logic        sx;

  always_comb begin
    mask       = 8'h01;
    misalign_o = 1'b0;
    case (size_i)
      SZ_B: mask = 8'h01;
      SZ_H: begin mask = 8'h03; misalign_o = off_i[0];      end
      SZ_W: begin mask = 8'h0F; misalign_o = |off_i[1:0];   end
      SZ_D: begin mask = 8'hFF; misalign_o = |off_i;        end
      default: ;
    endcase
    be_o = mask << off_i;
  end

  // Store data arrives right-aligned; move it up to the addressed lane.
  assign wsh = wdata_i << {off_i, 3'b000};
  assign rsh = word_i >> {off_i, 3'b000};

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      merged_o[8*i +: 8] = be_o[i] ? wsh[8*i +: 8] : word_i[8*i +: 8];
    end
  end

  always_comb begin
    rdata_o = rsh;
    sx      = 1'b0;
    case (size_i)
      SZ_B: begin sx = ~unsigned_i & rsh[7];  rdata_o = {{56{sx}}, rsh[7:0]};  end
      SZ_H: begin sx = ~unsigned_i & rsh[15]; rdata_o = {{48{sx}}, rsh[15:0]}; end
      SZ_W: begin sx = ~unsigned_i & rsh[31]; rdata_o = {{32{sx}}, rsh[31:0]}; end
      default: rdata_o = rsh;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed wait latency over a
// DEPTH_WORDS x 64 register array.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WE,
  input  logic [63:0] REQ_ADDR,
  input  logic [1:0]  REQ_SIZE,
  input  logic        REQ_UNSIGNED,
  input  logic [63:0] REQ_WDATA,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [63:0] RSP_RDATA,
  output logic        RSP_ERR
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, uns_q;
  logic [63:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic [63:0] rdata_q;
  logic        err_q;

  logic [63:0] mem_q [DEPTH_WORDS];

  logic        idle, exec;
  logic        cur_we, cur_uns;
  logic [63:0] cur_addr, cur_wdata;
  logic [1:0]  cur_size;
  logic        oor, misalign, err;
  logic [AW-1:0] widx;
  logic [63:0] word_rd, merged, ext;
  logic [7:0]  be;

  assign idle = (state_q == IDLE);

  // With LATENCY=0 the access runs on the accepting edge, so it must see the
  // live request; otherwise it uses the captured copy.
  assign cur_we    = idle ? REQ_WE       : we_q;
  assign cur_uns   = idle ? REQ_UNSIGNED : uns_q;
  assign cur_addr  = idle ? REQ_ADDR     : addr_q;
  assign cur_wdata = idle ? REQ_WDATA    : wdata_q;
  assign cur_size  = idle ? REQ_SIZE     : size_q;

  assign oor     = {3'b000, cur_addr[63:3]} >= 64'(DEPTH_WORDS);
  assign widx    = cur_addr[AW+2:3];
  assign word_rd = oor ? 64'd0 : mem_q[widx];
  assign err     = oor | misalign;

  dmem_lane_align u_align (
    .off_i      (cur_addr[2:0]),
    .size_i     (cur_size),
    .unsigned_i (cur_uns),
    .wdata_i    (cur_wdata),
    .word_i     (word_rd),
    .be_o       (be),
    .merged_o   (merged),
    .rdata_o    (ext),
    .misalign_o (misalign)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    exec    = 1'b0;
    case (state_q)
      IDLE: if (REQ_VALID) begin
        if (LATENCY == 0) begin
          state_d = RESP;
          exec    = 1'b1;
        end else begin
          state_d = BUSY;
          cnt_d   = 4'(LATENCY - 1);
        end
      end
      BUSY: if (cnt_q == 4'd0) begin
        state_d = RESP;
        exec    = 1'b1;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      RESP: if (RSP_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
      size_q  <= 2'd0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (idle && REQ_VALID) begin
        we_q    <= REQ_WE;
        uns_q   <= REQ_UNSIGNED;
        addr_q  <= REQ_ADDR;
        wdata_q <= REQ_WDATA;
        size_q  <= REQ_SIZE;
      end
      if (exec) begin
        err_q   <= err;
        rdata_q <= (err || cur_we) ? 64'd0 : ext;
      end
    end
  end

  // Storage survives reset; RESET only gates off a write on the same edge.
  always_ff @(posedge CLK) begin
    if (exec && cur_we && !err && !RESET && (be != 8'h00)) mem_q[widx] <= merged;
  end

  assign REQ_READY = idle;
  assign RSP_VALID = (state_q == RESP);
  assign RSP_RDATA = rdata_q;
  assign RSP_ERR   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-addressed memory model;
// a second LATENCY=0 instance covers back-to-back throughput.
module tb_dmem_responder;
  localparam int DEPTH  = 256;
  localparam int LAT    = 2;
  localparam int DEPTH0 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic        rst;
  logic        req_valid, req_ready, req_we, req_uns;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [63:0] rsp_rdata;

  logic        req_valid0, req_ready0, req_we0;
  logic [63:0] req_addr0, req_wdata0;
  logic        rsp_valid0, rsp_err0;
  logic [63:0] rsp_rdata0;
  logic        one = 1'b1;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
    .CLK(clk), .RESET(rst), .REQ_VALID(req_valid), .REQ_READY(req_ready),
    .REQ_WE(req_we), .REQ_ADDR(req_addr), .REQ_SIZE(req_size),
    .REQ_UNSIGNED(req_uns), .REQ_WDATA(req_wdata), .RSP_VALID(rsp_valid),
    .RSP_READY(rsp_ready), .RSP_RDATA(rsp_rdata), .RSP_ERR(rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH0), .LATENCY(0)) u_dut0 (
    .CLK(clk), .RESET(rst), .REQ_VALID(req_valid0), .REQ_READY(req_ready0),
    .REQ_WE(req_we0), .REQ_ADDR(req_addr0), .REQ_SIZE(2'd3),
    .REQ_UNSIGNED(1'b0), .REQ_WDATA(req_wdata0), .RSP_VALID(rsp_valid0),
    .RSP_READY(one), .RSP_RDATA(rsp_rdata0), .RSP_ERR(rsp_err0)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, act, exp);
    end
  endtask

  // Little-endian byte memory; a word access is just n consecutive bytes.
  logic [7:0] mem_m [DEPTH*8];

  function automatic void model(input logic we, input logic [63:0] addr, input logic [1:0] size,
                                input logic uns, input logic [63:0] wd,
                                output logic [63:0] rd, output logic err);
    int n = 1 << size;
    err = ((addr % 64'(n)) != 64'd0) || ((addr / 64'd8) >= 64'(DEPTH));
    rd  = 64'd0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < n; i++) mem_m[int'(addr) + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < n; i++) rd[8*i +: 8] = mem_m[int'(addr) + i];
        if (!uns && n < 8 && rd[8*n-1])
          for (int j = n; j < 8; j++) rd[8*j +: 8] = 8'hFF;
      end
    end
  endfunction

  task automatic drive(input logic we, input logic [63:0] addr, input logic [1:0] size,
                       input logic uns, input logic [63:0] wd);
    req_we = we; req_addr = addr; req_size = size; req_uns = uns; req_wdata = wd;
  endtask

  task automatic xact(input string tag, input logic we, input logic [63:0] addr,
                      input logic [1:0] size, input logic uns, input logic [63:0] wd,
                      input int hold);
    logic [63:0] er;
    logic        ee;
    int          lat;
    check({tag, "_reqrdy"}, 64'(req_ready), 64'd1);
    model(we, addr, size, uns, wd, er, ee);
    drive(we, addr, size, uns, wd);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    drive(1'($urandom), {$urandom, $urandom}, 2'($urandom), 1'($urandom), {$urandom, $urandom});
    lat = 1;
    while (!rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    check({tag, "_lat"}, 64'(lat), 64'(LAT + 1));
    check({tag, "_data"}, rsp_rdata, er);
    check({tag, "_err"}, 64'(rsp_err), 64'(ee));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, "_hold_vld"}, 64'(rsp_valid), 64'd1);
      check({tag, "_hold_data"}, rsp_rdata, er);
      check({tag, "_hold_err"}, 64'(rsp_err), 64'(ee));
      check({tag, "_hold_reqrdy"}, 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, "_done_vld"}, 64'(rsp_valid), 64'd0);
    check({tag, "_done_reqrdy"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] prior, rd, a, v0 [8];
    logic [1:0]  sz;
    logic        e;
    int          last;

    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    drive(1'b0, 64'd0, 2'd0, 1'b0, 64'd0);
    req_valid0 = 1'b0; req_we0 = 1'b0; req_addr0 = 64'd0; req_wdata0 = 64'd0;
    #1;
    check("rst_vld", 64'(rsp_valid), 64'd0);
    check("rst_data", rsp_rdata, 64'd0);
    check("rst_err", 64'(rsp_err), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_reqrdy", 64'(req_ready), 64'd1);

    for (int w = 0; w < DEPTH; w++) xact("init", 1'b1, 64'(w * 8), 2'd3, 1'b0, {$urandom, $urandom}, 0);

    xact("st_d10", 1'b1, 64'h10, 2'd3, 1'b0, 64'h1122334455667788, 0);
    xact("ld_d10", 1'b0, 64'h10, 2'd3, 1'b0, 64'd0, 0);
    xact("st_b13", 1'b1, 64'h13, 2'd0, 1'b0, 64'hAB, 0);
    xact("ld_d10b", 1'b0, 64'h10, 2'd3, 1'b1, 64'd0, 0);
    xact("ld_b13s", 1'b0, 64'h13, 2'd0, 1'b0, 64'd0, 0);
    xact("ld_b13u", 1'b0, 64'h13, 2'd0, 1'b1, 64'd0, 0);
    xact("ld_w12", 1'b0, 64'h12, 2'd2, 1'b0, 64'd0, 0);
    xact("st_h11", 1'b1, 64'h11, 2'd1, 1'b0, 64'hBEEF, 0);
    xact("ld_d10c", 1'b0, 64'h10, 2'd3, 1'b0, 64'd0, 0);
    xact("ld_oor", 1'b0, 64'(8 * DEPTH), 2'd3, 1'b0, 64'd0, 0);
    xact("st_oor", 1'b1, 64'(8 * DEPTH), 2'd0, 1'b0, 64'h5A, 0);
    xact("ld_hold", 1'b0, 64'h10, 2'd2, 1'b0, 64'd0, 5);

    for (int k = 0; k < 300; k++) begin
      sz = 2'($urandom);
      a  = 64'($urandom_range(8 * DEPTH + 15));
      if ($urandom_range(3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
      xact("rnd", 1'($urandom), a, sz, 1'($urandom), {$urandom, $urandom}, $urandom_range(2));
    end

    // Reset while BUSY on a store: the store must never land.
    model(1'b0, 64'h20, 2'd3, 1'b0, 64'd0, prior, e);
    drive(1'b1, 64'h20, 2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; #1;
    check("busyrst_vld", 64'(rsp_valid), 64'd0);
    check("busyrst_data", rsp_rdata, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("busyrst_reqrdy", 64'(req_ready), 64'd1);
    check("busyrst_vld2", 64'(rsp_valid), 64'd0);
    xact("busyrst_ld", 1'b0, 64'h20, 2'd3, 1'b0, 64'd0, 0);

    // Reset while RESP on a store: the committed write stays.
    model(1'b1, 64'h28, 2'd1, 1'b0, 64'h1234, rd, e);
    drive(1'b1, 64'h28, 2'd1, 1'b0, 64'h1234);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (LAT) @(posedge clk);
    #1;
    check("resprst_vld_pre", 64'(rsp_valid), 64'd1);
    rst = 1'b1; #1;
    check("resprst_vld", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    xact("resprst_ld", 1'b0, 64'h28, 2'd3, 1'b0, 64'd0, 0);

    // LATENCY=0 instance, RSP_READY tied high, REQ_VALID held high.
    for (int i = 0; i < 8; i++) v0[i] = {$urandom, $urandom};
    last = 0;
    req_valid0 = 1'b1;
    for (int k = 0; k < 16; k++) begin
      req_we0    = (k < 8);
      req_addr0  = 64'((k % 8) * 8);
      req_wdata0 = v0[k % 8];
      check("l0_reqrdy", 64'(req_ready0), 64'd1);
      @(posedge clk); #1;
      if (k > 0) check("l0_spacing", 64'(cyc - last), 64'd2);
      last = cyc;
      check("l0_vld", 64'(rsp_valid0), 64'd1);
      check("l0_data", rsp_rdata0, (k < 8) ? 64'd0 : v0[k % 8]);
      check("l0_err", 64'(rsp_err0), 64'd0);
      check("l0_busy_reqrdy", 64'(req_ready0), 64'd0);
      @(posedge clk); #1;
      check("l0_idle_vld", 64'(rsp_valid0), 64'd0);
    end
    req_valid0 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, number of 64-bit words in internal storage.
REQ-002 Parameter LATENCY, default 2, wait cycles between request acceptance and response (range 0..15).
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 REQ_VALID  input  1  initiator presents a request.
REQ-006 REQ_READY  output  1  responder can accept a request this cycle.
REQ-007 REQ_WE  input  1  1 = store, 0 = load.
REQ-008 REQ_ADDR  input  64  byte address.
REQ-009 REQ_SIZE  input  2  access size: 0 byte, 1 half, 2 word, 3 double.
REQ-010 REQ_UNSIGNED  input  1  load zero-extends when 1, sign-extends when 0.
REQ-011 REQ_WDATA  input  64  store data, right-aligned (bits [8*n-1:0] used).
REQ-012 RSP_VALID  output  1  response available.
REQ-013 RSP_READY  input  1  initiator accepts the response.
REQ-014 RSP_RDATA  output  64  load result, extended to 64 bits; 0 for stores and errors.
REQ-015 RSP_ERR  output  1  request was misaligned or out of range.

Function
REQ-016 FSM states IDLE, BUSY, RESP; REQ_READY SHALL be 1 only in IDLE.
REQ-017 Handshake: request accepted on the edge where REQ_VALID && REQ_READY; all request fields captured into internal registers at that edge.
REQ-018 Accept with LATENCY>0: IDLE->BUSY, wait counter loaded with LATENCY-1; BUSY decrements each cycle; at count 0 the next edge goes BUSY->RESP.
REQ-019 Accept with LATENCY=0: IDLE->RESP directly; response visible cycle after acceptance.
REQ-020 Total latency: RSP_VALID asserts exactly LATENCY+1 cycles after the accepting edge.
REQ-021 Access executes on the edge entering RESP: store merges byte lanes into storage word; load extracts lanes into RSP_RDATA register.
REQ-022 Lane selection: byte offset = addr[2:0]; word index = addr[63:3]; size n bytes = 1<<REQ_SIZE.
REQ-023 Store writes only the n bytes at offset..offset+n-1; other bytes of the word unchanged.
REQ-024 Load extracts n bytes at offset, shifts to bit 0, extends per REQ_UNSIGNED; size 3 ignores REQ_UNSIGNED.
REQ-025 Misaligned (offset not a multiple of n) or word index >= DEPTH_WORDS: RSP_ERR=1, RSP_RDATA=0, storage unmodified.
REQ-026 RSP_VALID, RSP_RDATA, RSP_ERR held stable in RESP until RSP_READY=1; that edge goes RESP->IDLE.
REQ-027 No pipelining: a new request is never accepted in the same cycle a response completes; REQ_READY rises the cycle after RESP->IDLE.
REQ-028 REQ_* inputs ignored outside IDLE; changes after acceptance do not affect the in-flight access.
REQ-029 RSP_READY ignored when RSP_VALID=0.

Reset
REQ-030 RESET asserted: state IDLE, counter 0, REQ_READY=1 (after release), RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0, immediately and asynchronously.
REQ-031 Storage contents SHALL NOT be cleared by RESET.
REQ-032 Reset during BUSY aborts the access; the pending store is not performed. Reset during RESP discards the response; a store already committed remains.

Structure
REQ-033 Shared package dmem_pkg holds state enum (IDLE/BUSY/RESP) and size encodings (SZ_B, SZ_H, SZ_W, SZ_D).
REQ-034 One combinational sub-module dmem_lane_align: byte-enable generation, store-data merge, load extract/extend, misalignment flag.
REQ-035 Storage is a register array DEPTH_WORDS x 64 inside dmem_responder.

Verification
REQ-036 Store double 0x1122334455667788 at 0x10, load double 0x10 -> RSP_RDATA=0x1122334455667788, RSP_ERR=0, RSP_VALID exactly 3 cycles after accept (LATENCY=2).
REQ-037 After REQ-036, store byte 0xAB at 0x13, load double 0x10 -> 0x11223344AB667788; load byte signed 0x13 -> 0xFFFFFFFFFFFFFFAB; unsigned -> 0x00000000000000AB.
REQ-038 Load word at 0x12 -> RSP_ERR=1, RSP_RDATA=0; store half at 0x11 -> RSP_ERR=1, word 0x10 unchanged; address 8*DEPTH_WORDS -> RSP_ERR=1.
REQ-039 Hold RSP_READY=0 for 5 cycles in RESP -> outputs stable, REQ_READY=0 throughout; RSP_READY=1 -> IDLE next edge, REQ_READY=1.
REQ-040 Assert RESET mid-BUSY on a store of 0xFF..FF to 0x20 -> RSP_VALID=0 immediately, IDLE after release, later load 0x20 returns prior value.
REQ-041 LATENCY=0 build: back-to-back requests with RSP_READY tied 1 -> one response every 2 cycles, data correct.
